t03_wishbone_queued_manager: RTL

Parametrised Wishbone classic-cycle bus manager that sits between a CPU/peripheral client and the Wishbone interconnect. Client requests are buffered in a DEPTH-entry FIFO. Transactions are issued one at a time. Each completes with a one-cycle response carrying read data and a status: OK, bus error or timeout. It succeeds the single-request manager by adding parametrised widths, request queuing, ERR_I handling and a watchdog timeout.

---
 rtl/t03_wb_pkg.sv | 39 +++
 rtl/t03_wishbone_queued_manager_fifo.sv | 59 +++++
 rtl/t03_wishbone_queued_manager.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/t03_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t03_wb_pkg
// Brief    : Shared types and constants for the queued Wishbone manager:
//            FSM state enum, default-width request record, completion status
//            codes and a helper that sizes a flattened request entry.
// Revision : 1.0 - initial release
// ============================================================================
package t03_wb_pkg;

    // Manager FSM states; single-bit encoding kept explicit.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

    // Default bus widths, used for the record view of a queued request.
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic                   we;
        logic [WB_ADDR_W-1:0]   adr;
        logic [WB_DATA_W-1:0]   dat;
        logic [WB_DATA_W/8-1:0] sel;
    } wb_req_t;

    // Completion status codes.
    localparam logic [1:0] c_STAT_OK  = 2'd0;
    localparam logic [1:0] c_STAT_ERR = 2'd1;
    localparam logic [1:0] c_STAT_TMO = 2'd2;

    // Bits needed to hold one flattened request {we, adr, dat, sel}.
    function automatic int req_width(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/t03_wishbone_queued_manager_fifo.sv
`default_nettype none
// ============================================================================
// Module   : t03_wb_req_fifo
// Brief    : Synchronous request FIFO. Pointers carry one extra wrap bit so
//            full/empty come from a plain pointer compare.
// Revision : 1.0 - initial release
// ============================================================================
module t03_wb_req_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Same index bits with differing wrap bits means the writer lapped the reader.
    assign o_full  = (r_wr[PTR_W-1] != r_rd[PTR_W-1]) &&
                     (r_wr[PTR_W-2:0] == r_rd[PTR_W-2:0]);
    assign o_empty = (r_wr == r_rd);
    assign o_count = r_wr - r_rd;
    assign o_data  = r_mem[r_rd[PTR_W-2:0]];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[PTR_W-2:0]] <= i_data;
        end
    end

    // Advance the pointers; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/t03_wishbone_queued_manager.sv
`default_nettype none
// ============================================================================
// Module   : t03_wishbone_queued_manager
// Brief    : Wishbone classic-cycle manager. Client requests are queued and
//            issued one at a time; each ends with a one-cycle response
//            reporting OK, bus error or watchdog timeout.
// Revision : 1.0 - initial release
// ============================================================================
module t03_wishbone_queued_manager
    import t03_wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                REQ_VALID_I,
    output logic                REQ_READY_O,
    input  logic                REQ_WE_I,
    input  logic [ADDR_W-1:0]   REQ_ADR_I,
    input  logic [DATA_W-1:0]   REQ_DAT_I,
    input  logic [DATA_W/8-1:0] REQ_SEL_I,
    output logic                RSP_VALID_O,
    output logic [DATA_W-1:0]   RSP_DAT_O,
    output logic                RSP_ERR_O,
    output logic                RSP_TIMEOUT_O,
    output logic                BUSY_O,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic                ACK_I,
    input  logic                ERR_I,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    output logic                WE_O,
    output logic                STB_O,
    output logic                CYC_O
);

    localparam int c_SEL_W = DATA_W / 8;
    localparam int c_REQ_W = req_width(ADDR_W, DATA_W);
    localparam int c_PTR_W = $clog2(DEPTH) + 1;
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [0:0] c_ST_IDLE = IDLE;
    localparam logic [0:0] c_ST_WAIT = WAIT;

    logic [0:0]          r_state;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_dat;
    logic [c_SEL_W-1:0]  r_sel;
    logic                r_we;
    logic                r_cyc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic                r_rsp_tmo;
    logic [DATA_W-1:0]   r_rsp_dat;

    logic [c_REQ_W-1:0]  w_req_in;
    logic [c_REQ_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic [c_PTR_W-1:0]  w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_head_we;
    logic [ADDR_W-1:0]   w_head_adr;
    logic [DATA_W-1:0]   w_head_dat;
    logic [c_SEL_W-1:0]  w_head_sel;
    logic                w_done;
    logic [1:0]          w_status;

    // Requests travel through the queue flattened as {we, adr, dat, sel}.
    assign w_req_in   = {REQ_WE_I, REQ_ADR_I, REQ_DAT_I, REQ_SEL_I};
    assign w_head_we  = w_head[c_REQ_W-1];
    assign w_head_adr = w_head[c_REQ_W-2 -: ADDR_W];
    assign w_head_dat = w_head[c_SEL_W +: DATA_W];
    assign w_head_sel = w_head[c_SEL_W-1:0];

    // A full queue refuses the push even if the head leaves this cycle.
    assign w_push = REQ_VALID_I && !w_full;
    assign w_pop  = (r_state == c_ST_IDLE) && !w_empty;

    t03_wb_req_fifo #(
        .WIDTH (c_REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (CLK),
        .rst_n   (nRST),
        .i_push  (w_push),
        .i_data  (w_req_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Decide whether the in-flight cycle ends now: error beats ack beats timeout.
    always_comb begin
        w_done   = 1'b0;
        w_status = c_STAT_OK;
        if (ERR_I) begin
            w_done   = 1'b1;
            w_status = c_STAT_ERR;
        end else if (ACK_I) begin
            w_done   = 1'b1;
        end else if ((TIMEOUT != 0) && (r_cnt == c_TMO_LAST)) begin
            w_done   = 1'b1;
            w_status = c_STAT_TMO;
        end
    end

    // Issue queued requests one at a time and retire them with a response pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= c_ST_IDLE;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            r_rsp_dat   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (!w_empty) begin
                    r_adr   <= w_head_adr;
                    r_dat   <= w_head_we ? w_head_dat : '0;
                    r_sel   <= w_head_sel;
                    r_we    <= w_head_we;
                    r_cyc   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= c_ST_WAIT;
                end
            end else begin
                if (w_done) begin
                    r_adr       <= '0;
                    r_dat       <= '0;
                    r_sel       <= '0;
                    r_we        <= 1'b0;
                    r_cyc       <= 1'b0;
                    r_state     <= c_ST_IDLE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= (w_status == c_STAT_ERR);
                    r_rsp_tmo   <= (w_status == c_STAT_TMO);
                    // Read data is only captured from a clean acknowledge.
                    if ((w_status == c_STAT_OK) && !r_we) begin
                        r_rsp_dat <= DAT_I;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign REQ_READY_O   = !w_full;
    assign BUSY_O        = (r_state == c_ST_WAIT) || (w_count != '0);
    assign ADR_O         = r_adr;
    assign DAT_O         = r_dat;
    assign SEL_O         = r_sel;
    assign WE_O          = r_we;
    assign STB_O         = r_cyc;
    assign CYC_O         = r_cyc;
    assign RSP_VALID_O   = r_rsp_valid;
    assign RSP_ERR_O     = r_rsp_err;
    assign RSP_TIMEOUT_O = r_rsp_tmo;
    assign RSP_DAT_O     = r_rsp_dat;

endmodule
`default_nettype wire
